ext_mem_loader: RTL and testbench
=================================

Name: ext_mem_loader

Overview:
- Host-side initiator for the processor's external memory-access ports: the other end of the addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext and *_2 interfaces.
- Parses a byte-stream command protocol (valid/ready) and performs these operations:
  - writes program words into instruction memory;
  - writes data words into data memory;
  - reads data memory back onto an output byte stream;
  - drives the processor enable.
- Sits between the test/host link and the processor top.

Parameters:
- IMEM_ADDR_W, 9, instruction-memory word-index width; legal word index is 0 .. 2^IMEM_ADDR_W-1.
- DMEM_ADDR_W, 10, data-memory word-index width.
- RD_LAT, 1, cycles from ren_ext_2 high to valid rdata_ext_2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  command byte valid
- in_data  in  8  command byte
- in_ready  out  1  loader accepts in_data this cycle
- out_valid  out  1  response byte valid
- out_data  out  8  response byte
- out_ready  in  1  sink accepts out_data
- addr_ext  out  64  instruction-memory byte address
- wen_ext  out  1  instruction-memory write strobe
- ren_ext  out  1  instruction-memory read strobe (tied 0)
- wdata_ext  out  32  instruction word
- rdata_ext  in  32  unused
- addr_ext_2  out  64  data-memory byte address
- wen_ext_2  out  1  data-memory write strobe
- ren_ext_2  out  1  data-memory read strobe
- wdata_ext_2  out  64  data word
- rdata_ext_2  in  64  data-memory read data
- cpu_enable  out  1  processor run enable
- busy  out  1  frame in progress (state != IDLE)
- err  out  1  one-cycle error pulse

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
  - On rst, every output is 0: in_ready, out_valid, out_data, all addr/data/strobe outputs, cpu_enable, busy, err.
  - The FSM goes to IDLE.
  - rst mid-frame abandons the frame. No strobe is asserted on the cycle after rst.
- Byte transfer: a byte transfers when in_valid && in_ready, and likewise for out_valid && out_ready.
  - in_ready is 1 only in the byte-collecting states (IDLE, HDR, PAYLOAD).
  - out_data is held stable while out_valid && !out_ready.
- Frame format (bytes, MSB first):
  - Byte 0: opcode.
  - Bytes 1-2: 16-bit word index.
  - Byte 3: count-1, giving 1..256 words.
  - Payload follows, for write frames only.
- Opcodes:
  - 0x10 WR_IMEM: 4 payload bytes per word.
  - 0x20 WR_DMEM: 8 payload bytes per word.
  - 0x30 RD_DMEM: no payload; 8 response bytes per word.
  - 0x40 RUN: single byte; sets cpu_enable=1.
  - 0x50 HALT: single byte; sets cpu_enable=0.
- Error conditions:
  - Unknown opcode: err pulse; byte dropped; stay IDLE.
  - Any 0x10/0x20/0x30 while cpu_enable=1: err pulse; opcode dropped; stay IDLE.
  - Range check: index+count-1 >= 2^ADDR_W for the target memory gives an err pulse at the end of the header.
    - A write frame's payload is still consumed, with all strobes suppressed.
    - A read frame returns to IDLE with no output bytes.
- FSM states: IDLE -> HDR (3 bytes) -> one of PAYLOAD, RD_REQ, or IDLE.
- Write path: PAYLOAD -> WRITE -> PAYLOAD, or IDLE after the last word.
  - WRITE is one cycle: the strobe is high for that cycle only, with addr and data stable in the same cycle.
  - in_ready=0 during WRITE.
- Read path: RD_REQ -> RD_WAIT -> RD_SEND -> RD_REQ, or IDLE after the last word.
  - RD_REQ: ren_ext_2 high for one cycle.
  - RD_WAIT: lasts RD_LAT cycles; the word is captured at the end of the wait.
  - RD_SEND: emits 8 bytes MSB first, stalling on out_ready.
- Address arithmetic:
  - Byte address = index*4 (instruction memory) or index*8 (data memory), zero-extended to 64 bits.
  - The index increments by 1 per word.
  - The word counter is 9 bits, so count-1 = 0xFF yields exactly 256 words with no wrap.
- Write timing: the last word's strobe fires 1 cycle after its final payload byte is accepted.
- RUN/HALT take effect on the cycle after the byte is accepted.
- HALT is accepted at any time in IDLE, including when cpu_enable=0, where it is a no-op.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Every write frame carries one trailing checksum byte: the sum mod 256 of all payload bytes.
  - After accepting it, the loader emits one ack byte: 0xA5 on match, 0xE1 on mismatch. A mismatch also gives an err pulse.
  - Writes are not withheld.
- Undefined: no checksum byte and no ack byte; the write frame ends after the payload.

Decomposition:
- Package ext_mem_loader_pkg holds:
  - opcode localparams (OP_WR_IMEM, OP_WR_DMEM, OP_RD_DMEM, OP_RUN, OP_HALT);
  - the FSM state enum;
  - ack constants (ACK_OK=0xA5, ACK_BAD=0xE1).
- Natural sub-module: ext_loader_serdes.
  - Byte-to-word shift-in: 4 or 8 bytes, MSB first.
  - Word-to-byte shift-out with the out_valid/out_ready hold.
  - The main FSM only sequences.

Test Plan:
- Write imem: 10 00 00 00 DE AD BE EF -> one cycle with wen_ext=1, addr_ext=0, wdata_ext=0xDEADBEEF; busy falls next cycle.
- Write dmem: 20 00 03 01, then 16 bytes 01..10 -> wen_ext_2 twice.
  - addr 24: data 0x0102030405060708.
  - addr 32: data 0x090A0B0C0D0E0F10.
- Read back: 30 00 03 01 -> ren_ext_2 at addr 24, then 32; out bytes 01..10 in order, with out_ready toggled every other cycle and no byte lost or duplicated.
- Run gating: 40, then 10 … -> cpu_enable=1, err pulse, no wen_ext. Then 50 -> cpu_enable=0.
- Boundary: 20 03 FF 01 with DMEM_ADDR_W=10 -> err pulse after header; 16 payload bytes consumed; no wen_ext_2; back to IDLE.
- Reset mid-payload: rst after 5 payload bytes of a dmem write -> all outputs 0; no strobe. A following valid frame executes normally. With LOADER_CHECKSUM_EN, a bad checksum returns 0xE1.

Source files
------------

// File: rtl/ext_mem_loader_pkg.sv
// Shared opcodes, FSM states and ack bytes for the external-memory loader.
package ext_mem_loader_pkg;

    localparam logic [7:0] OP_WR_IMEM = 8'h10;
    localparam logic [7:0] OP_WR_DMEM = 8'h20;
    localparam logic [7:0] OP_RD_DMEM = 8'h30;
    localparam logic [7:0] OP_RUN     = 8'h40;
    localparam logic [7:0] OP_HALT    = 8'h50;

    localparam logic [7:0] ACK_OK  = 8'hA5;
    localparam logic [7:0] ACK_BAD = 8'hE1;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_HDR     = 4'd1,
        ST_PAYLOAD = 4'd2,
        ST_WRITE   = 4'd3,
        ST_RD_REQ  = 4'd4,
        ST_RD_WAIT = 4'd5,
        ST_RD_SEND = 4'd6,
        ST_CSUM    = 4'd7,
        ST_ACK     = 4'd8
    } state_e;

    // True when the last word of the frame lands outside a 2^addr_w-word memory.
    function automatic logic span_exceeds(input logic [15:0] idx,
                                          input logic [7:0]  cnt_m1,
                                          input int unsigned addr_w);
        logic [16:0] last;
        last = {1'b0, idx} + {9'h000, cnt_m1};
        return (last >> addr_w) != '0;
    endfunction

endpackage

// File: rtl/ext_loader_serdes.sv
// Byte/word conversion for the loader: MSB-first shift-in of payload bytes and
// MSB-first shift-out of a loaded word, holding out_data while the sink stalls.
module ext_loader_serdes (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_shift,
    input  logic [7:0]  in_byte,
    output logic [63:0] in_word,
    input  logic        out_load,
    input  logic [63:0] out_word,
    input  logic [3:0]  out_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_done
);

    logic [63:0] sreg;
    logic [63:0] oreg;
    logic [3:0]  out_left;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg     <= '0;
            oreg     <= '0;
            out_left <= '0;
        end else begin
            if (in_shift) begin
                sreg <= {sreg[55:0], in_byte};
            end
            if (out_load) begin
                oreg     <= out_word;
                out_left <= out_len;
            end else if (out_valid && out_ready) begin
                oreg     <= {oreg[55:0], 8'h00};
                out_left <= out_left - 4'd1;
            end
        end
    end

    assign in_word   = sreg;
    assign out_valid = (out_left != '0);
    assign out_data  = oreg[63:56];
    assign out_done  = out_valid && out_ready && (out_left == 4'd1);

endmodule

// File: rtl/ext_mem_loader.sv
// Host-side command-stream loader driving the processor's external imem/dmem ports.
// Optional LOADER_CHECKSUM_EN: trailing checksum byte per write frame, answered by an ack byte.
module ext_mem_loader
    import ext_mem_loader_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W = 9,
    parameter int unsigned DMEM_ADDR_W = 10,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        err
);

    state_e      state;
    logic [7:0]  op;
    logic [1:0]  hdr_cnt;
    logic [15:0] idx;
    logic [8:0]  words_left;
    logic [2:0]  byte_cnt;
    logic [7:0]  lat_cnt;
    logic        suppress;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        in_fire;
    logic        hdr_range_bad;
    logic [2:0]  last_byte;
    logic [63:0] word;
    logic        out_load;
    logic [63:0] out_word;
    logic [3:0]  out_len;
    logic        out_done;
    logic        unused_rdata;

    assign unused_rdata  = ^rdata_ext;
    assign in_fire       = in_valid && in_ready;
    assign last_byte     = (op == OP_WR_IMEM) ? 3'd3 : 3'd7;
    assign hdr_range_bad = span_exceeds(idx, in_data,
                                        (op == OP_WR_IMEM) ? IMEM_ADDR_W : DMEM_ADDR_W);

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE, ST_HDR, ST_PAYLOAD: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM:                     in_ready = 1'b1;
`endif
                default:                     in_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        out_load = 1'b0;
        out_word = '0;
        out_len  = '0;
        if (state == ST_RD_WAIT && lat_cnt == '0) begin
            out_load = 1'b1;
            out_word = rdata_ext_2;
            out_len  = 4'd8;
        end
`ifdef LOADER_CHECKSUM_EN
        if (state == ST_CSUM && in_fire) begin
            out_load = 1'b1;
            out_word = {(in_data == csum) ? ACK_OK : ACK_BAD, 56'h0};
            out_len  = 4'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op         <= '0;
            hdr_cnt    <= '0;
            idx        <= '0;
            words_left <= '0;
            byte_cnt   <= '0;
            lat_cnt    <= '0;
            suppress   <= 1'b0;
            cpu_enable <= 1'b0;
            err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: if (in_fire) begin
                    op      <= in_data;
                    hdr_cnt <= '0;
                    case (in_data)
                        OP_WR_IMEM, OP_WR_DMEM, OP_RD_DMEM: begin
                            if (cpu_enable) err   <= 1'b1;
                            else            state <= ST_HDR;
                        end
                        OP_RUN:  cpu_enable <= 1'b1;
                        OP_HALT: cpu_enable <= 1'b0;
                        default: err <= 1'b1;
                    endcase
                end
                ST_HDR: if (in_fire) begin
                    hdr_cnt <= hdr_cnt + 2'd1;
                    if (hdr_cnt != 2'd2) begin
                        idx <= {idx[7:0], in_data};
                    end else begin
                        words_left <= {1'b0, in_data} + 9'd1;
                        byte_cnt   <= '0;
                        suppress   <= hdr_range_bad;
                        err        <= hdr_range_bad;
`ifdef LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                        if (op == OP_RD_DMEM) state <= hdr_range_bad ? ST_IDLE : ST_RD_REQ;
                        else                  state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: if (in_fire) begin
                    byte_cnt <= byte_cnt + 3'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum     <= csum + in_data;
`endif
                    if (byte_cnt == last_byte) begin
                        byte_cnt <= '0;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    words_left <= words_left - 9'd1;
                    idx        <= idx + 16'd1;
                    if (words_left == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= ST_CSUM;
`else
                        state <= ST_IDLE;
`endif
                    end else begin
                        state <= ST_PAYLOAD;
                    end
                end
                ST_RD_REQ: begin
                    lat_cnt <= 8'(RD_LAT - 1);
                    state   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (lat_cnt == '0) state   <= ST_RD_SEND;
                    else               lat_cnt <= lat_cnt - 8'd1;
                end
                ST_RD_SEND: if (out_done) begin
                    words_left <= words_left - 9'd1;
                    idx        <= idx + 16'd1;
                    state      <= (words_left == 9'd1) ? ST_IDLE : ST_RD_REQ;
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: if (in_fire) begin
                    err   <= (in_data != csum);
                    state <= ST_ACK;
                end
                ST_ACK: if (out_done) state <= ST_IDLE;
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    ext_loader_serdes u_serdes (
        .clk       (clk),
        .rst       (rst),
        .in_shift  (in_fire && state == ST_PAYLOAD),
        .in_byte   (in_data),
        .in_word   (word),
        .out_load  (out_load),
        .out_word  (out_word),
        .out_len   (out_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_done  (out_done)
    );

    assign addr_ext    = {46'h0, idx, 2'b00};
    assign addr_ext_2  = {45'h0, idx, 3'b000};
    assign wdata_ext   = word[31:0];
    assign wdata_ext_2 = word;
    assign wen_ext     = (state == ST_WRITE) && (op == OP_WR_IMEM) && !suppress;
    assign wen_ext_2   = (state == ST_WRITE) && (op == OP_WR_DMEM) && !suppress;
    assign ren_ext     = 1'b0;
    assign ren_ext_2   = (state == ST_RD_REQ);
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_ext_mem_loader.sv
// Self-checking bench for ext_mem_loader: scoreboard queues for strobes and
// response bytes, plus direct per-scenario checks.
module tb_ext_mem_loader;
    import ext_mem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;
    logic        cpu_enable;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    ext_mem_loader #(.IMEM_ADDR_W(9), .DMEM_ADDR_W(10), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    int          checks = 0;
    int          passed = 0;
    int          err_seen = 0;
    int          err_expected = 0;
    wr_t         exp_imem[$];
    wr_t         exp_dmem[$];
    logic [63:0] exp_rd[$];
    logic [7:0]  exp_out[$];
    wr_t         mon_e;
    logic [63:0] mon_a;
    logic [7:0]  mon_b;
    logic [63:0] dmem_model [0:1023];
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  pl_sum;
`endif

    // Data memory with one cycle of read latency
    always @(posedge clk) begin
        if (rst) begin
            rdata_ext_2 <= '0;
        end else begin
            if (wen_ext_2) dmem_model[addr_ext_2[12:3]] <= wdata_ext_2;
            if (ren_ext_2) rdata_ext_2 <= dmem_model[addr_ext_2[12:3]];
        end
    end

    // Scoreboard: every strobe and every transferred response byte pops an expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (wen_ext) begin
                checks++;
                if (exp_imem.size() == 0) begin
                    $display("FAIL imem_write: unexpected strobe addr=%h data=%h", addr_ext, wdata_ext);
                end else begin
                    mon_e = exp_imem.pop_front();
                    if (addr_ext !== mon_e.addr || {32'h0, wdata_ext} !== mon_e.data)
                        $display("FAIL imem_write: got addr=%h data=%h, want addr=%h data=%h",
                                 addr_ext, wdata_ext, mon_e.addr, mon_e.data);
                    else passed++;
                end
            end
            if (wen_ext_2) begin
                checks++;
                if (exp_dmem.size() == 0) begin
                    $display("FAIL dmem_write: unexpected strobe addr=%h data=%h", addr_ext_2, wdata_ext_2);
                end else begin
                    mon_e = exp_dmem.pop_front();
                    if (addr_ext_2 !== mon_e.addr || wdata_ext_2 !== mon_e.data)
                        $display("FAIL dmem_write: got addr=%h data=%h, want addr=%h data=%h",
                                 addr_ext_2, wdata_ext_2, mon_e.addr, mon_e.data);
                    else passed++;
                end
            end
            if (ren_ext_2) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    $display("FAIL dmem_read: unexpected read strobe addr=%h", addr_ext_2);
                end else begin
                    mon_a = exp_rd.pop_front();
                    if (addr_ext_2 !== mon_a)
                        $display("FAIL dmem_read: got addr=%h, want addr=%h", addr_ext_2, mon_a);
                    else passed++;
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_out.size() == 0) begin
                    $display("FAIL out_byte: unexpected byte %h", out_data);
                end else begin
                    mon_b = exp_out.pop_front();
                    if (out_data !== mon_b)
                        $display("FAIL out_byte: got %h, want %h", out_data, mon_b);
                    else passed++;
                end
            end
            if (err) err_seen++;
        end
    end

    // Starts and ends on a negedge; in_valid is dropped once the byte has been taken.
    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL in_ready_timeout: byte %h, in_ready=%b want 1", b, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_payload(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
        pl_sum = pl_sum + b;
`endif
        send_byte(b);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic send_csum(input logic [7:0] b, input logic [7:0] ack);
        int unsigned n;
        n = 0;
        exp_out.push_back(ack);
        send_byte(b);
        while (exp_out.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_out.size() != 0) begin
            checks++;
            $display("FAIL ack_timeout: ack byte not emitted, want %h", ack);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_reset;
        logic [240:0] outs;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        rdata_ext = '0;
        repeat (3) @(negedge clk);
        outs = {in_ready, out_valid, out_data, addr_ext, wen_ext, ren_ext, wdata_ext,
                addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, cpu_enable, busy, err};
        checks++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h, want all zero", outs);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        else passed++;
    endtask

    task automatic test_write_imem;
        logic [7:0] pl [4];
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
        pl_sum = '0;
`endif
        exp_imem.push_back('{addr: 64'd0, data: 64'hDEADBEEF});
        send_byte(OP_WR_IMEM); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_payload(pl[i]);
        checks++;
        if (wen_ext !== 1'b1 || addr_ext !== 64'd0 || wdata_ext !== 32'hDEADBEEF)
            $display("FAIL imem_strobe_timing: wen=%b addr=%h data=%h, want 1 0 deadbeef",
                     wen_ext, addr_ext, wdata_ext);
        else passed++;
`ifdef LOADER_CHECKSUM_EN
        send_csum(pl_sum, ACK_OK);
`else
        @(negedge clk);
`endif
        checks++;
        if (busy !== 1'b0 || wen_ext !== 1'b0)
            $display("FAIL imem_frame_end: busy=%b wen=%b, want 0 0", busy, wen_ext);
        else passed++;
    endtask

    task automatic test_write_dmem;
`ifdef LOADER_CHECKSUM_EN
        pl_sum = '0;
`endif
        exp_dmem.push_back('{addr: 64'd24, data: 64'h0102030405060708});
        exp_dmem.push_back('{addr: 64'd32, data: 64'h090A0B0C0D0E0F10});
        send_byte(OP_WR_DMEM); send_byte(8'h00); send_byte(8'h03); send_byte(8'h01);
        for (int i = 1; i <= 16; i++) send_payload(8'(i));
        checks++;
        if (wen_ext_2 !== 1'b1 || addr_ext_2 !== 64'd32)
            $display("FAIL dmem_last_strobe: wen=%b addr=%h, want 1 20", wen_ext_2, addr_ext_2);
        else passed++;
`ifdef LOADER_CHECKSUM_EN
        send_csum(pl_sum, ACK_OK);
`else
        @(negedge clk);
`endif
        checks++;
        if (busy !== 1'b0)
            $display("FAIL dmem_frame_end: busy=%b, want 0", busy);
        else passed++;
    endtask

    task automatic test_read_back;
        int unsigned n;
        out_ready = 1'b0;
        exp_rd.push_back(64'd24);
        exp_rd.push_back(64'd32);
        for (int i = 1; i <= 16; i++) exp_out.push_back(8'(i));
        send_byte(OP_RD_DMEM); send_byte(8'h00); send_byte(8'h03); send_byte(8'h01);
        n = 0;
        while ((exp_out.size() != 0 || busy) && n < 200) begin
            @(posedge clk);
            #2 out_ready = ~out_ready;
            n++;
        end
        @(negedge clk);
        checks++;
        if (exp_out.size() != 0 || busy !== 1'b0)
            $display("FAIL read_back_done: bytes left=%0d busy=%b, want 0 0", exp_out.size(), busy);
        else passed++;
        out_ready = 1'b1;
    endtask

    task automatic test_run_gating;
        send_byte(OP_RUN);
        checks++;
        if (cpu_enable !== 1'b1) $display("FAIL run_enable: cpu_enable=%b, want 1", cpu_enable);
        else passed++;
        send_byte(OP_WR_IMEM);
        err_expected++;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL run_gated_write: err=%b busy=%b, want 1 0", err, busy);
        else passed++;
        send_byte(8'h77);
        err_expected++;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL unknown_opcode: err=%b busy=%b, want 1 0", err, busy);
        else passed++;
        send_byte(OP_HALT);
        checks++;
        if (cpu_enable !== 1'b0) $display("FAIL halt_disable: cpu_enable=%b, want 0", cpu_enable);
        else passed++;
        send_byte(OP_HALT);
        checks++;
        if (cpu_enable !== 1'b0 || err !== 1'b0)
            $display("FAIL halt_noop: cpu_enable=%b err=%b, want 0 0", cpu_enable, err);
        else passed++;
    endtask

    task automatic test_boundary;
`ifdef LOADER_CHECKSUM_EN
        pl_sum = '0;
`endif
        send_byte(OP_WR_DMEM); send_byte(8'h03); send_byte(8'hFF); send_byte(8'h01);
        err_expected++;
        checks++;
        if (err !== 1'b1 || busy !== 1'b1)
            $display("FAIL range_err: err=%b busy=%b, want 1 1", err, busy);
        else passed++;
        for (int i = 1; i <= 16; i++) send_payload(8'(i));
`ifdef LOADER_CHECKSUM_EN
        send_csum(pl_sum, ACK_OK);
`else
        @(negedge clk);
`endif
        checks++;
        if (busy !== 1'b0) $display("FAIL range_frame_end: busy=%b, want 0", busy);
        else passed++;
        // out-of-range read: no strobe and no response
        send_byte(OP_RD_DMEM); send_byte(8'h03); send_byte(8'hFF); send_byte(8'h01);
        err_expected++;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL range_read: err=%b busy=%b, want 1 0", err, busy);
        else passed++;
    endtask

    task automatic test_reset_mid_payload;
        logic [240:0] outs;
        send_byte(OP_WR_DMEM); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        rst = 1'b1;
        @(negedge clk);
        outs = {in_ready, out_valid, out_data, addr_ext, wen_ext, ren_ext, wdata_ext,
                addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, cpu_enable, busy, err};
        checks++;
        if (outs !== '0) $display("FAIL mid_reset_outputs: got %h, want all zero", outs);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
        pl_sum = '0;
`endif
        exp_imem.push_back('{addr: 64'd4, data: 64'h11223344});
        send_byte(OP_WR_IMEM); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_payload(8'h11); send_payload(8'h22); send_payload(8'h33); send_payload(8'h44);
`ifdef LOADER_CHECKSUM_EN
        err_expected++;
        send_csum(pl_sum + 8'h01, ACK_BAD);
`else
        @(negedge clk);
`endif
        checks++;
        if (busy !== 1'b0) $display("FAIL post_reset_frame: busy=%b, want 0", busy);
        else passed++;
    endtask

    task automatic test_final;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_imem.size() != 0 || exp_dmem.size() != 0 || exp_rd.size() != 0 || exp_out.size() != 0)
            $display("FAIL scoreboard_drain: imem=%0d dmem=%0d rd=%0d out=%0d left, want 0",
                     exp_imem.size(), exp_dmem.size(), exp_rd.size(), exp_out.size());
        else passed++;
        checks++;
        if (err_seen != err_expected)
            $display("FAIL err_pulses: got %0d, want %0d", err_seen, err_expected);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_write_imem;
        test_write_dmem;
        test_read_back;
        test_run_gating;
        test_boundary;
        test_reset_mid_payload;
        test_final;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

endmodule
